// File: rtl/instr_encoder.sv
// Single-entry MIPS instruction encoder with valid/ready handshakes on both sides.
// It tags each emitted word with a wrapping 8-bit word address and keeps a sticky illegal-op flag.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [7:0]  addr,
    output logic        err,
    input  logic        flush
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_NOP  = 4'd10;

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_tgt
    );
        logic [31:0] w;
        case (op)
            OP_ADD:  w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100000};
            OP_SUB:  w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100010};
            OP_AND:  w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100100};
            OP_OR:   w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100101};
            OP_SLT:  w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b101010};
            OP_LW:   w = {6'b100011, f_rs, f_rt, f_imm};
            OP_SW:   w = {6'b101011, f_rs, f_rt, f_imm};
            OP_BEQ:  w = {6'b000100, f_rs, f_rt, f_imm};
            OP_ADDI: w = {6'b001000, f_rs, f_rt, f_imm};
            OP_J:    w = {6'b000010, f_tgt};
            OP_NOP:  w = 32'h00000000;
            default: w = 32'h00000000;
        endcase
        return w;
    endfunction

    logic        state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  addr_q, addr_d;
    logic        err_q, err_d;
    logic        in_hs_s, out_hs_s, legal_s;

    // Handshake qualification; reset and flush block acceptance outright.
    always_comb begin
        in_ready = 1'b0;
        if (reset || flush) begin
            in_ready = 1'b0;
        end else begin
            in_ready = (state_q == EMPTY) || out_ready;
        end
        in_hs_s  = in_valid && in_ready;
        out_hs_s = (state_q == FULL) && out_ready;
        legal_s  = (op_sel <= OP_NOP);
    end

    // Next-state: flush dominates; an illegal request only raises err.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        if (flush) begin
            state_d = EMPTY;
            addr_d  = 8'd0;
        end else begin
            if (out_hs_s) begin
                state_d = EMPTY;
                addr_d  = addr_q + 8'd1;
            end else begin
                addr_d  = addr_q;
            end
            if (in_hs_s) begin
                if (legal_s) begin
                    state_d = FULL;
                    instr_d = encode(op_sel, rs, rt, rd, imm, target);
                end else begin
                    err_d   = 1'b1;
                end
            end else begin
                instr_d = instr_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            instr_q <= 32'h00000000;
            addr_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign instr     = instr_q;
    assign addr      = addr_q;
    assign err       = err_q;

endmodule
